// File: rtl/interrupt_ack_sequencer_if.sv
// Interrupt acknowledge sequencer bus bundle.
// Groups the configuration, priority-resolver, CPU strobe and sequencer
// outputs into one interface.
//   master : controller/bench side; drives the configuration, winner and inta_n,
//            and observes the outputs
//   slave  : sequencer side
// Signals:
//   mode, auto_eoi, highest_priority_interrupt[7:0], icw2[7:0],
//   address_low[2:0], call_interval_4, inta_n   -> toward sequencer
//   int_out, freeze, acknowledge, ack_level[7:0], end_of_interrupt[7:0],
//   data_out[7:0], data_oe                      <- from sequencer
interface interrupt_ack_sequencer_if;
    logic       mode;
    logic       auto_eoi;
    logic [7:0] highest_priority_interrupt;
    logic [7:0] icw2;
    logic [2:0] address_low;
    logic       call_interval_4;
    logic       inta_n;
    logic       int_out;
    logic       freeze;
    logic       acknowledge;
    logic [7:0] ack_level;
    logic [7:0] end_of_interrupt;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output mode, auto_eoi, highest_priority_interrupt, icw2,
               address_low, call_interval_4, inta_n,
        input  int_out, freeze, acknowledge, ack_level, end_of_interrupt,
               data_out, data_oe
    );

    modport slave (
        input  mode, auto_eoi, highest_priority_interrupt, icw2,
               address_low, call_interval_4, inta_n,
        output int_out, freeze, acknowledge, ack_level, end_of_interrupt,
               data_out, data_oe
    );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// 8259A-style interrupt acknowledge sequencer.
// Raises int_out, counts INTA pulses (2 in 8086 mode, 3 in 8080 mode), latches
// the winning level for the ISR, drives the vector/CALL bytes and issues the
// optional automatic-EOI clear at the end of the sequence.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : interrupt_ack_sequencer_if.slave (configuration, winner, inta_n in;
//            int_out, freeze, acknowledge, ack_level, end_of_interrupt,
//            data_out, data_oe out; all outputs registered)
// Parameter:
//   SYNC_STAGES : flops in the inta_n synchronizer (2 or more)
// Build option:
//   INTA_SEQ_AEOI_EN : when defined, auto_eoi is honoured and a one-cycle
//                      end_of_interrupt pulse is issued in DONE; otherwise
//                      end_of_interrupt stays 8'h00.
module interrupt_ack_sequencer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    interrupt_ack_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACK1 = 3'd2,
        ACK2 = 3'd3,
        ACK3 = 3'd4,
        DONE = 3'd5
    } state_e;

    localparam int unsigned LVL_W  = 3;
    localparam int unsigned BYTE_W = 8;

    state_e                     state_q, state_d;
    logic [SYNC_STAGES-1:0]     sync_q;
    logic                       strb, strb_q, fe, re;
    logic                       int_out_q, int_out_d;
    logic                       freeze_q, freeze_d;
    logic                       ack_q, ack_d;
    logic [BYTE_W-1:0]          ack_level_q, ack_level_d;
    logic [BYTE_W-1:0]          eoi_q, eoi_d;
    logic [BYTE_W-1:0]          data_out_q, data_out_d;
    logic                       data_oe_q, data_oe_d;
    logic                       spurious_q, spurious_d;
    logic [BYTE_W-1:0]          aeoi_mask;
    logic [LVL_W-1:0]           lvl;
    logic                       byte_def;
    logic [BYTE_W-1:0]          byte_val;

    // One-hot level to its binary index
    function automatic logic [LVL_W-1:0] onehot_to_bin(input logic [BYTE_W-1:0] oh);
        logic [LVL_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (oh[i]) bin = LVL_W'(i);
        end
        return bin;
    endfunction

    // Synchronized strobe and its edges
    assign strb = sync_q[SYNC_STAGES-1];
    assign fe   = strb_q & ~strb;
    assign re   = ~strb_q & strb;

    // Clear mask presented on entry to DONE
`ifdef INTA_SEQ_AEOI_EN
    assign aeoi_mask = (bus.auto_eoi && !spurious_q) ? ack_level_q : BYTE_W'(0);
`else
    logic unused_auto_eoi;
    assign unused_auto_eoi = bus.auto_eoi;
    assign aeoi_mask       = BYTE_W'(0);
`endif

    // State, synchronizer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            strb_q      <= 1'b1;
            state_q     <= IDLE;
            int_out_q   <= 1'b0;
            freeze_q    <= 1'b0;
            ack_q       <= 1'b0;
            ack_level_q <= '0;
            eoi_q       <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.inta_n};
            strb_q      <= strb;
            state_q     <= state_d;
            int_out_q   <= int_out_d;
            freeze_q    <= freeze_d;
            ack_q       <= ack_d;
            ack_level_q <= ack_level_d;
            eoi_q       <= eoi_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            spurious_q  <= spurious_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        int_out_d   = int_out_q;
        freeze_d    = freeze_q;
        ack_d       = 1'b0;
        ack_level_d = ack_level_q;
        eoi_d       = '0;
        data_out_d  = data_out_q;
        data_oe_d   = 1'b0;
        spurious_d  = spurious_q;
        lvl         = '0;
        byte_def    = 1'b0;
        byte_val    = '0;

        case (state_q)
            IDLE: begin
                // Strobes seen here are unsolicited and ignored
                int_out_d = 1'b0;
                freeze_d  = 1'b0;
                if (bus.highest_priority_interrupt != '0) begin
                    state_d   = REQ;
                    int_out_d = 1'b1;
                end
            end
            REQ: begin
                if (fe) begin
                    state_d   = ACK1;
                    int_out_d = 1'b0;
                    freeze_d  = 1'b1;
                    if (bus.highest_priority_interrupt == '0) begin
                        // Request withdrawn: report IR7, leave the ISR alone
                        spurious_d  = 1'b1;
                        ack_level_d = 8'h80;
                    end else begin
                        spurious_d  = 1'b0;
                        ack_level_d = bus.highest_priority_interrupt;
                        ack_d       = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (fe) state_d = ACK2;
            end
            ACK2: begin
                if (bus.mode && re) begin
                    state_d  = DONE;
                    freeze_d = 1'b0;
                    eoi_d    = aeoi_mask;
                end else if (!bus.mode && fe) begin
                    state_d = ACK3;
                end
            end
            ACK3: begin
                if (re) begin
                    state_d  = DONE;
                    freeze_d = 1'b0;
                    eoi_d    = aeoi_mask;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus byte for the state being entered; enabled while the strobe is low
        lvl = onehot_to_bin(ack_level_d);
        case (state_d)
            ACK1: begin
                byte_def = ~bus.mode;
                byte_val = 8'hCD;
            end
            ACK2: begin
                byte_def = 1'b1;
                if (bus.mode)                 byte_val = {bus.icw2[7:3], lvl};
                else if (bus.call_interval_4) byte_val = {bus.address_low, lvl, 2'b00};
                else                          byte_val = {bus.address_low[2:1], lvl, 3'b000};
            end
            ACK3: begin
                byte_def = 1'b1;
                byte_val = bus.icw2;
            end
            default: begin
                byte_def = 1'b0;
            end
        endcase
        if (byte_def) begin
            data_out_d = byte_val;
            data_oe_d  = ~strb;
        end
    end

    assign bus.int_out          = int_out_q;
    assign bus.freeze           = freeze_q;
    assign bus.acknowledge      = ack_q;
    assign bus.ack_level        = ack_level_q;
    assign bus.end_of_interrupt = eoi_q;
    assign bus.data_out         = data_out_q;
    assign bus.data_oe          = data_oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: directed scenarios plus
// randomized INTA sequences compared against a transaction-level model.
module tb_interrupt_ack_sequencer;

    localparam int unsigned SYNC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    interrupt_ack_sequencer_if bus ();

    interrupt_ack_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor, sampled 1 time unit after each rising edge
    int         cyc_n = 0;
    int         ack_cnt, got_n, eoi_cycles, eoi_frz_bad, unstable, frz_cycles;
    int         ff_cyc, ir_cyc, eoi_cyc;
    logic [7:0] got_b [4];
    logic [7:0] eoi_val, d_p;
    logic       oe_p = 1'b0, frz_p = 1'b0, int_p = 1'b0;

    task automatic clr();
        ack_cnt = 0; got_n = 0; eoi_cycles = 0; eoi_frz_bad = 0;
        unstable = 0; frz_cycles = 0; ff_cyc = -1; ir_cyc = -1;
        eoi_cyc = -2; eoi_val = 8'h00;
    endtask

    always @(posedge clk) begin
        #1;
        cyc_n++;
        if (bus.acknowledge) ack_cnt++;
        if (bus.data_oe && !oe_p && got_n < 4) begin
            got_b[got_n] = bus.data_out;
            got_n++;
        end
        if (bus.data_oe && oe_p && bus.data_out !== d_p) unstable++;
        if (bus.end_of_interrupt != 8'h00) begin
            eoi_cycles++;
            eoi_val = bus.end_of_interrupt;
            eoi_cyc = cyc_n;
            if (bus.freeze) eoi_frz_bad++;
        end
        if (bus.freeze) frz_cycles++;
        if (frz_p && !bus.freeze) ff_cyc = cyc_n;
        if (!int_p && bus.int_out) ir_cyc = cyc_n;
        oe_p  = bus.data_oe;
        d_p   = bus.data_out;
        frz_p = bus.freeze;
        int_p = bus.int_out;
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_int"},  32'(bus.int_out),          0);
        check({pfx, "_frz"},  32'(bus.freeze),           0);
        check({pfx, "_ack"},  32'(bus.acknowledge),      0);
        check({pfx, "_lvl"},  32'(bus.ack_level),        0);
        check({pfx, "_eoi"},  32'(bus.end_of_interrupt), 0);
        check({pfx, "_dout"}, 32'(bus.data_out),         0);
        check({pfx, "_doe"},  32'(bus.data_oe),          0);
    endtask

    // One full acknowledge sequence checked against the transaction model
    task automatic run_seq(input bit m, input bit ae, input logic [7:0] win,
                           input logic [7:0] i2, input logic [2:0] al, input bit c4,
                           input bit spur, input bit keep);
        logic [7:0] lvl_oh, exp_eoi;
        logic [7:0] eb [3];
        int         lv, en, np, w;
        bit         waited;

        bus.mode = m; bus.auto_eoi = ae; bus.icw2 = i2;
        bus.address_low = al; bus.call_interval_4 = c4;

        // Model: level, bytes and clear mask from the device rules
        lvl_oh = spur ? 8'h80 : win;
        lv     = $clog2(lvl_oh);
        if (m) begin
            en = 1;
            eb[0] = 8'((i2 & 8'hF8) + lv);
        end else begin
            en = 3;
            eb[0] = 8'hCD;
            eb[1] = c4 ? 8'(al * 32 + lv * 4) : 8'((al / 2) * 64 + lv * 8);
            eb[2] = i2;
        end
`ifdef INTA_SEQ_AEOI_EN
        exp_eoi = (ae && !spur) ? lvl_oh : 8'h00;
`else
        exp_eoi = 8'h00;
`endif
        np = m ? 2 : 3;

        if (!bus.int_out) begin
            bus.highest_priority_interrupt = win;
            cyc(1);
            check("int_latency", 32'(bus.int_out), 1);
        end else begin
            bus.highest_priority_interrupt = win;
        end
        waited = 1'b0;
        for (int k = 0; k < 8 && !waited; k++) begin
            if (bus.int_out) waited = 1'b1;
            else cyc(1);
        end
        if (!waited) check("int_timeout", 32'(bus.int_out), 1);
        if (spur) bus.highest_priority_interrupt = 8'h00;
        clr();

        for (int p = 0; p < np; p++) begin
            bus.inta_n = 1'b0;
            w = int'($urandom_range(4, 7));
            if (p == 0) begin
                cyc(SYNC + 1);
                check("ack_latency", 32'(bus.acknowledge), 32'(!spur));
                cyc(w - int'(SYNC) - 1);
            end else begin
                cyc(w);
            end
            bus.inta_n = 1'b1;
            cyc(int'($urandom_range(4, 7)));
            if (p == 0 && !keep && !spur) bus.highest_priority_interrupt = 8'h00;
        end
        cyc(6);

        check("ack_count", 32'(ack_cnt), 32'(!spur));
        check("ack_level", 32'(bus.ack_level), 32'(lvl_oh));
        check("byte_count", 32'(got_n), 32'(en));
        for (int i = 0; i < en; i++) begin
            if (i < got_n) check($sformatf("byte%0d", i), 32'(got_b[i]), 32'(eb[i]));
        end
        check("data_stable", 32'(unstable), 0);
        check("eoi_value", 32'(eoi_val), 32'(exp_eoi));
        check("eoi_cycles", 32'(eoi_cycles), 32'(exp_eoi != 8'h00));
        check("eoi_freeze", 32'(eoi_frz_bad), 0);
        if (exp_eoi != 8'h00) check("eoi_with_unfreeze", 32'(eoi_cyc), 32'(ff_cyc));
        check("end_freeze", 32'(bus.freeze), 0);
        check("end_int", 32'(bus.int_out), 32'(keep));
        if (keep) check("rereq_gap", 32'(ir_cyc - ff_cyc), 2);
    endtask

    initial begin
        logic [7:0] win;
        bit         sp;

        rst_n = 1'b0;
        bus.mode = 1'b1; bus.auto_eoi = 1'b0; bus.highest_priority_interrupt = 8'h00;
        bus.icw2 = 8'h00; bus.address_low = 3'b000; bus.call_interval_4 = 1'b0;
        bus.inta_n = 1'b1;
        clr();
        cyc(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cyc(2);

        // Directed scenarios
        run_seq(1'b1, 1'b0, 8'b0010_0000, 8'h40, 3'b000, 1'b0, 1'b0, 1'b0);
        run_seq(1'b0, 1'b0, 8'b0000_1000, 8'h12, 3'b101, 1'b1, 1'b0, 1'b0);
        run_seq(1'b1, 1'b1, 8'b0010_0000, 8'h40, 3'b000, 1'b0, 1'b0, 1'b0);
        run_seq(1'b1, 1'b0, 8'b0000_0100, 8'h40, 3'b000, 1'b0, 1'b1, 1'b0);
        run_seq(1'b0, 1'b1, 8'b0100_0000, 8'hA5, 3'b011, 1'b0, 1'b0, 1'b0);

        // Reset pulsed while the second 8086 pulse is being served
        bus.mode = 1'b1; bus.auto_eoi = 1'b1; bus.icw2 = 8'h40;
        bus.highest_priority_interrupt = 8'b0010_0000;
        cyc(3);
        clr();
        bus.inta_n = 1'b0; cyc(5);
        bus.inta_n = 1'b1; cyc(5);
        bus.inta_n = 1'b0; cyc(6);
        check("pre_rst_doe", 32'(bus.data_oe), 1);
        rst_n = 1'b0;
        bus.inta_n = 1'b1;
        bus.highest_priority_interrupt = 8'h00;
        #1;
        check_reset_outputs("midrst");
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        check("midrst_no_eoi", 32'(eoi_cycles), 0);
        run_seq(1'b1, 1'b1, 8'b0000_0010, 8'h88, 3'b000, 1'b0, 1'b0, 1'b0);

        // Unsolicited INTA pulses while idle
        clr();
        for (int p = 0; p < 2; p++) begin
            bus.inta_n = 1'b0; cyc(5);
            bus.inta_n = 1'b1; cyc(5);
        end
        cyc(4);
        check("unsol_ack", 32'(ack_cnt), 0);
        check("unsol_oe", 32'(got_n), 0);
        check("unsol_frz", 32'(frz_cycles), 0);
        check("unsol_int", 32'(bus.int_out), 0);

        // Request still present in DONE, then the follow-on sequence
        run_seq(1'b1, 1'b0, 8'b0000_0100, 8'h28, 3'b000, 1'b0, 1'b0, 1'b1);
        run_seq(1'b0, 1'b1, 8'b0100_0000, 8'h3C, 3'b110, 1'b0, 1'b0, 1'b0);

        // Randomized sequences
        for (int t = 0; t < 24; t++) begin
            win = 8'(1) << $urandom_range(0, 7);
            sp  = ($urandom_range(0, 7) == 0);
            run_seq(1'($urandom), 1'($urandom), win, 8'($urandom), 3'($urandom),
                    1'($urandom), sp, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Control-logic sequencer for the 8259A-compatible interrupt controller, sitting between the priority resolver, the in-service register and the CPU bus. It raises INT toward the CPU and counts the CPU's INTA pulses: two in 8086 mode, three in 8080 mode. It latches the winning level into the in-service register, drives the vector or CALL bytes onto the data bus, and issues the automatic-EOI clear at the end of the sequence.

## Interface
- SYNC_STAGES, 2, number of flops in the inta_n synchronizer (minimum 2).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  1 = 8086 (two INTA pulses), 0 = 8080 (three INTA pulses).
- auto_eoi  in  1  ICW4 AEOI bit.
- highest_priority_interrupt  in  8  one-hot winner from the priority resolver; 0 = none pending.
- icw2  in  8  8086: T7–T3 in [7:3]; 8080: high address byte A15–A8.
- address_low  in  3  ICW1 A7–A5 (8080 only).
- call_interval_4  in  1  ICW1 ADI: 1 = interval 4, 0 = interval 8.
- inta_n  in  1  CPU acknowledge strobe, asynchronous to clk, active low.
- int_out  out  1  interrupt request to the CPU.
- freeze  out  1  high from the first INTA until the sequence ends; the IRR holds its value while high.
- acknowledge  out  1  one-cycle pulse that sets ack_level in the ISR.
- ack_level  out  8  one-hot level latched at the first INTA.
- end_of_interrupt  out  8  one-cycle AEOI clear mask.
- data_out  out  8  byte driven to the data bus.
- data_oe  out  1  data bus output enable.

## Operation
- States: IDLE, REQ, ACK1, ACK2, ACK3, DONE.
- inta_n passes through SYNC_STAGES flops. A falling edge of the synchronized strobe ("fe") advances the sequence.
- IDLE: when highest_priority_interrupt != 0, go to REQ and set int_out=1.
- REQ: on fe, latch the level and go to ACK1. If highest_priority_interrupt==0 at fe (request withdrawn), the sequence is spurious: ack_level=8'h80, no acknowledge pulse.
- ACK1, non-spurious: pulse acknowledge once; freeze=1; int_out=0.
- ACK1 data byte: 8080 drives 8'hCD (CALL). 8086 drives nothing; data_oe stays 0 for the first pulse.
- ACK1 on fe: go to ACK2.
- ACK2 data byte, 8086: {icw2[7:3], level[2:0]}, where level is the binary encoding of ack_level.
- ACK2 data byte, 8080, interval 4: {address_low, level, 2'b00}.
- ACK2 data byte, 8080, interval 8: {address_low[2:1], level, 3'b000}.
- ACK2 on rising edge of the synchronized strobe: 8086 goes to DONE; 8080 waits for fe and then goes to ACK3.
- ACK3 (8080 only): drive icw2. On rising edge of the synchronized strobe, go to DONE.
- DONE: for one cycle, if AEOI is active and the sequence is not spurious, end_of_interrupt=ack_level. Clear freeze, return to IDLE.
- data_oe=1 only while in ACK1/ACK2/ACK3 with the synchronized strobe low and a byte defined for that state.
- Unsolicited INTA, i.e. fe while in IDLE: ignored, no outputs change.

## Timing
- Reset values: int_out=0, freeze=0, acknowledge=0, ack_level=0, end_of_interrupt=0, data_out=0, data_oe=0; state=IDLE.
- Reset asserted mid-sequence returns to IDLE immediately and drives all outputs to their reset values. No AEOI is issued.
- int_out rises 1 cycle after highest_priority_interrupt becomes nonzero in IDLE.
- INTA latency: fe is seen SYNC_STAGES+1 cycles after inta_n falls.
- acknowledge, freeze and the int_out drop all take effect in the cycle after fe.
- data_out is registered and valid no later than data_oe.
- The DONE pulse occurs 1 cycle after the final synchronized rising edge of the strobe.
- A new request present in DONE is taken up in IDLE on the next cycle; back-to-back sequences need no idle gap beyond that.

## Configuration
- INTA_SEQ_AEOI_EN defined: auto_eoi is honoured and the DONE-cycle end_of_interrupt pulse is generated.
- INTA_SEQ_AEOI_EN undefined: auto_eoi is ignored and end_of_interrupt is tied to 8'h00. EOI is then left to the command path.

## Test plan
- 8086 mode, auto_eoi=0, winner=8'b00100000, icw2=8'h40, two INTA pulses -> acknowledge pulses once with ack_level=8'h20. Second pulse drives data_out=8'h45 with data_oe=1. end_of_interrupt stays 0.
- 8080 mode, interval 4, address_low=3'b101, icw2=8'h12, winner=IR3, three INTA pulses -> bytes driven are 8'hCD, then 8'hAC, then 8'h12.
- With INTA_SEQ_AEOI_EN defined: 8086 sequence on IR5 with auto_eoi=1 -> end_of_interrupt=8'h20 for exactly 1 cycle in DONE, and freeze drops in the same cycle.
- Spurious: request removed before the first INTA, 8086 mode, icw2=8'h40 -> no acknowledge pulse, data_out=8'h47, no AEOI.
- rst_n pulsed low during ACK2 -> all outputs return to reset values immediately. A fresh request afterwards completes a normal sequence.
- INTA pulses while IDLE, plus a new request arriving in DONE -> the IDLE pulses are ignored, and int_out reasserts 1 cycle after returning to IDLE.
